kanagawa_thread_launcher: RTL and testbench



---
 rtl/kanagawa_thread_launcher_pkg.sv | 14 +
 rtl/kanagawa_thread_launcher_thread_counter.sv | 32 +++
 rtl/kanagawa_thread_launcher.sv | 100 ++++++++++
 tb/tb_kanagawa_thread_launcher.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/kanagawa_thread_launcher_pkg.sv
// Shared types for the thread launcher: FSM state encoding and the count/ID type.
package kanagawa_thread_launcher_pkg;

  localparam int THREAD_COUNT_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } launcher_state_t;

  typedef logic [THREAD_COUNT_WIDTH_DEFAULT-1:0] thread_count_t;

endpackage

// File: rtl/kanagawa_thread_launcher_thread_counter.sv
// Issue-side thread ID generator: counts handshakes from zero and flags the final ID.
module KanagawaThreadCounter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_in,
  input  logic         incr_in,
  input  logic [W-1:0] max_thread_id_in,
  input  logic         only_one_thread_in,
  output logic [W-1:0] thread_id_out,
  output logic         count_reached_out
);

  logic [W-1:0] thread_id;

  // Runs one past max_thread_id so the value doubles as the issued count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thread_id <= '0;
    end else if (clear_in) begin
      thread_id <= '0;
    end else if (incr_in) begin
      thread_id <= thread_id + W'(1);
    end
  end

  assign thread_id_out     = thread_id;
  assign count_reached_out = only_one_thread_in ? (thread_id == '0)
                                                : (thread_id == max_thread_id_in);

endmodule

// File: rtl/kanagawa_thread_launcher.sv
// Launches a batch of thread IDs downstream and pulses done once all have retired.
module kanagawa_thread_launcher
  import kanagawa_thread_launcher_pkg::*;
#(
  parameter int THREAD_COUNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid_in,
  output logic                          req_ready_out,
  input  logic [THREAD_COUNT_WIDTH-1:0] req_count_in,
  output logic                          thread_valid_out,
  input  logic                          thread_ready_in,
  output logic [THREAD_COUNT_WIDTH-1:0] thread_id_out,
  output logic                          thread_last_out,
  input  logic                          retire_in,
  output logic                          batch_done_out,
  output logic                          busy_out,
  output logic                          error_out
);

  localparam int W = THREAD_COUNT_WIDTH;

  launcher_state_t state, state_next;
  logic [W-1:0] count, retired, retired_next, issued;
  logic         done, done_next, error;
  logic         accept, handshake, reached, retire_ok;

  assign accept    = (state == IDLE) && req_valid_in;
  assign handshake = (state == ISSUE) && thread_ready_in;
  // Only registered issued/retired are compared, so a same-cycle handshake never enables a retire.
  assign retire_ok    = retire_in && (state != IDLE) && (retired < issued);
  assign retired_next = retired + {{(W-1){1'b0}}, retire_ok};

  KanagawaThreadCounter #(.W(W)) u_thread_counter (
    .clk                (clk),
    .rst                (rst),
    .clear_in           (accept),
    .incr_in            (handshake),
    .max_thread_id_in   (count - W'(1)),
    .only_one_thread_in (count == W'(1)),
    .thread_id_out      (issued),
    .count_reached_out  (reached)
  );

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (req_count_in == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (handshake && reached) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (retired_next == count) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      retired <= '0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
      if (accept) begin
        count   <= req_count_in;
        retired <= '0;
      end else begin
        retired <= retired_next;
      end
      if (retire_in && !retire_ok) begin
        error <= 1'b1;
      end
    end
  end

  assign req_ready_out    = (state == IDLE);
  assign busy_out         = (state != IDLE);
  assign thread_valid_out = (state == ISSUE);
  assign thread_id_out    = issued;
  assign thread_last_out  = (state == ISSUE) && reached;
  assign batch_done_out   = done;
  assign error_out        = error;

endmodule

// File: tb/tb_kanagawa_thread_launcher.sv
// Directed bench for kanagawa_thread_launcher: per-cycle vector table plus corner-case sequences.
module tb_kanagawa_thread_launcher;
  import kanagawa_thread_launcher_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid_in;
  logic          req_ready_out;
  thread_count_t req_count_in;
  logic          thread_valid_out;
  logic          thread_ready_in;
  thread_count_t thread_id_out;
  logic          thread_last_out;
  logic          retire_in;
  logic          batch_done_out;
  logic          busy_out;
  logic          error_out;

  int tests = 0;
  int fails = 0;

  kanagawa_thread_launcher #(.THREAD_COUNT_WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_in     (req_valid_in),
    .req_ready_out    (req_ready_out),
    .req_count_in     (req_count_in),
    .thread_valid_out (thread_valid_out),
    .thread_ready_in  (thread_ready_in),
    .thread_id_out    (thread_id_out),
    .thread_last_out  (thread_last_out),
    .retire_in        (retire_in),
    .batch_done_out   (batch_done_out),
    .busy_out         (busy_out),
    .error_out        (error_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rv;
    thread_count_t cnt;
    logic          rdy;
    logic          ret;
    logic          e_ready;
    logic          e_valid;
    thread_count_t e_id;
    logic          e_last;
    logic          e_done;
    logic          e_busy;
    logic          e_err;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs mid-cycle, then sample 1 ns after the following rising edge.
  task automatic step(input logic rv, input thread_count_t cnt, input logic rdy, input logic ret);
    @(negedge clk);
    req_valid_in    = rv;
    req_count_in    = cnt;
    thread_ready_in = rdy;
    retire_in       = ret;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b1;
    req_valid_in    = 1'b0;
    req_count_in    = '0;
    thread_ready_in = 1'b0;
    retire_in       = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    int issued_m, retired_m, dones, seq_err, err_seen, post;
    logic exp_valid;

    // rv cnt rdy ret | ready valid id last done busy err
    vecs[0]  = '{1'b1, 32'd5, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd4, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst             = 1'b1;
    req_valid_in    = 1'b0;
    req_count_in    = '0;
    thread_ready_in = 1'b0;
    retire_in       = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset ready", req_ready_out, 1);
    chk("reset valid", thread_valid_out, 0);
    chk("reset id", thread_id_out, 0);
    chk("reset last", thread_last_out, 0);
    chk("reset done", batch_done_out, 0);
    chk("reset busy", busy_out, 0);
    chk("reset error", error_out, 0);
    rst = 1'b0;

    // Count=5 with lagging retires, count=0, count=1 with stalls, back-to-back count=2, IDLE retire.
    for (int i = 0; i < 21; i++) begin
      step(vecs[i].rv, vecs[i].cnt, vecs[i].rdy, vecs[i].ret);
      chk($sformatf("vec%0d ready", i), req_ready_out, vecs[i].e_ready);
      chk($sformatf("vec%0d valid", i), thread_valid_out, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d id", i), thread_id_out, vecs[i].e_id);
        chk($sformatf("vec%0d last", i), thread_last_out, vecs[i].e_last);
      end
      chk($sformatf("vec%0d done", i), batch_done_out, vecs[i].e_done);
      chk($sformatf("vec%0d busy", i), busy_out, vecs[i].e_busy);
      chk($sformatf("vec%0d error", i), error_out, vecs[i].e_err);
      $display("[TB] vec%0d id=%0d valid=%0b done=%0b err=%0b", i, thread_id_out,
               thread_valid_out, batch_done_out, error_out);
    end

    // Count=100, random ready, retires limited to the outstanding count.
    do_reset();
    step(1'b1, 32'd100, 1'b0, 1'b0);
    chk("c100 accept valid", thread_valid_out, 1);
    issued_m = 0; retired_m = 0; dones = 0; seq_err = 0; err_seen = 0; post = 0;
    for (int cyc = 0; cyc < 3000 && post < 4; cyc++) begin
      @(negedge clk);
      if (batch_done_out) dones++;
      if (error_out) err_seen = 1;
      exp_valid = (issued_m < 100);
      if (thread_valid_out !== exp_valid) seq_err++;
      if (thread_valid_out && (thread_id_out !== thread_count_t'(issued_m))) seq_err++;
      if (thread_valid_out && (thread_last_out !== (issued_m == 99))) seq_err++;
      req_valid_in    = 1'b0;
      thread_ready_in = 1'($urandom_range(0, 1));
      retire_in       = (retired_m < issued_m) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (thread_valid_out && thread_ready_in) issued_m++;
      if (retire_in) retired_m++;
      if (retired_m == 100) post++;
    end
    chk("c100 sequence errors", seq_err, 0);
    chk("c100 issued", issued_m, 100);
    chk("c100 retired", retired_m, 100);
    chk("c100 done pulses", dones, 1);
    chk("c100 error seen", err_seen, 0);
    $display("[TB] c100 issued=%0d retired=%0d dones=%0d", issued_m, retired_m, dones);

    // Retire with nothing outstanding in ISSUE: error set, retire not counted.
    do_reset();
    step(1'b1, 32'd3, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("extra retire error", error_out, 1);
    chk("extra retire id held", thread_id_out, 0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("c3 last", thread_last_out, 1);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("c3 drain valid", thread_valid_out, 0);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("c3 retire1 done", batch_done_out, 0);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("c3 retire2 done", batch_done_out, 0);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("c3 retire3 done", batch_done_out, 1);
    chk("c3 error sticky", error_out, 1);
    $display("[TB] c3 extra-retire sequence done=%0b err=%0b", batch_done_out, error_out);

    // Async reset mid-ISSUE at ID 3, then a fresh count=2 batch.
    do_reset();
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("idle retire error", error_out, 1);
    step(1'b1, 32'd10, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("pre-reset id", thread_id_out, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst ready", req_ready_out, 1);
    chk("async rst valid", thread_valid_out, 0);
    chk("async rst busy", busy_out, 0);
    chk("async rst error", error_out, 0);
    chk("async rst id", thread_id_out, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'd2, 1'b1, 1'b0);
    chk("post-rst id0", thread_id_out, 0);
    chk("post-rst valid0", thread_valid_out, 1);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("post-rst id1", thread_id_out, 1);
    chk("post-rst last1", thread_last_out, 1);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("post-rst drain", thread_valid_out, 0);
    $display("[TB] reset-mid-issue sequence complete");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
